// File: rtl/round_key_store_pkg.sv
// Shared types and constants for the AES-128 round key store.
// Provides the key/word/index types, the schedule length and the
// controller state encoding used by the store, its register file and
// its bus interface.
package round_key_store_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_WIDTH  = 128;
    localparam int NUM_SLOTS  = NUM_ROUNDS + 1;

    typedef logic [31:0]  word_t;
    typedef word_t [3:0]  key_t;        // word 3 is the most significant
    typedef logic [3:0]   round_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        CAPTURE,
        READY
    } rks_fsm_e;

endpackage

// File: rtl/round_key_store_if.sv
// Bus bundle around the round key store.
// Groups the host key load, the key expansion handshake, the round
// datapath read port and the status flags.
//   master : host / key expansion / round datapath side
//   slave  : round_key_store side
interface round_key_store_if;
    import round_key_store_pkg::*;

    logic       load_key;
    key_t       cipher_key;
    logic       start_expansion;
    key_t       prev_key;
    key_t       next_key;
    logic       finished_expansion;
    round_idx_t rd_round;
    key_t       rd_key;
    logic       keys_ready;
    logic       busy;
    logic       sched_err;

    modport master (
        output load_key, cipher_key, next_key, finished_expansion, rd_round,
        input  start_expansion, prev_key, rd_key, keys_ready, busy, sched_err
    );

    modport slave (
        input  load_key, cipher_key, next_key, finished_expansion, rd_round,
        output start_expansion, prev_key, rd_key, keys_ready, busy, sched_err
    );

endinterface

// File: rtl/round_key_store_regfile.sv
// Eleven-slot round key storage.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (clears all slots)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : registered read port, out-of-range index reads zero
//   slot0        : live contents of slot 0 (the cipher key)
// A read and write of the same slot in one cycle returns the old contents.
module round_key_regfile
    import round_key_store_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  round_idx_t waddr,
    input  key_t       wdata,
    input  round_idx_t raddr,
    output key_t       rdata,
    output key_t       slot0
);

    key_t mem [NUM_SLOTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr <= round_idx_t'(NUM_ROUNDS))) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (raddr <= round_idx_t'(NUM_ROUNDS)) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

    assign slot0 = mem[0];

endmodule

// File: rtl/round_key_store.sv
// AES-128 round key store.
// Captures the cipher key into slot 0, kicks key expansion, captures the
// ten streamed round keys into slots 1..10 and serves any slot through a
// registered read port.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : load_key/cipher_key in; start_expansion/prev_key out;
//                  next_key/finished_expansion in; rd_round in, rd_key out;
//                  keys_ready, busy, sched_err status out
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no schedule held since reset
// START   | cipher key in slot 0, start_expansion pulsed this cycle
// CAPTURE | writing next_key into slot wr_idx (1..10)
// READY   | full schedule held, keys_ready asserted
module round_key_store
    import round_key_store_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    round_key_store_if.slave bus
);

    rks_fsm_e   state, state_nxt;
    round_idx_t wr_idx;
    logic       sched_err_q;
    logic       load_ok;
    logic       last_write;
    logic       start_c, busy_c, ready_c;
    logic       wr_en;
    round_idx_t wr_addr;
    key_t       wr_data;
    key_t       rd_data;
    key_t       slot0;

    assign load_ok    = bus.load_key && ((state == IDLE) || (state == READY));
    assign last_write = (wr_idx == round_idx_t'(NUM_ROUNDS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_ok) state_nxt = START;
            START:   state_nxt = CAPTURE;
            CAPTURE: if (last_write) state_nxt = READY;
            READY:   if (load_ok) state_nxt = START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_c = 1'b0;
        busy_c  = 1'b0;
        ready_c = 1'b0;
        case (state)
            START:   begin start_c = 1'b1; busy_c = 1'b1; end
            CAPTURE: busy_c  = 1'b1;
            READY:   ready_c = 1'b1;
            default: ;
        endcase
    end

    // Counter alone decides termination; wr_idx rests at 0 outside CAPTURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            wr_idx <= '0;
        else if (state == START)                 wr_idx <= 4'd1;
        else if (state == CAPTURE && !last_write) wr_idx <= wr_idx + 4'd1;
        else                                     wr_idx <= '0;
    end

    // finished_expansion must coincide exactly with the last write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sched_err_q <= 1'b0;
        else if (load_ok)
            sched_err_q <= 1'b0;
        else if (state == CAPTURE && (bus.finished_expansion != last_write))
            sched_err_q <= 1'b1;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (load_ok) begin
            wr_en   = 1'b1;
            wr_data = bus.cipher_key;
        end else if (state == CAPTURE) begin
            wr_en   = 1'b1;
            wr_addr = wr_idx;
            wr_data = bus.next_key;
        end
    end

    round_key_regfile u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr   (bus.rd_round),
        .rdata   (rd_data),
        .slot0   (slot0)
    );

    assign bus.start_expansion = start_c;
    assign bus.busy            = busy_c;
    assign bus.keys_ready      = ready_c;
    assign bus.sched_err       = sched_err_q;
    assign bus.rd_key          = rd_data;
    assign bus.prev_key        = slot0;

endmodule

// File: tb/tb_round_key_store.sv
// Bench for round_key_store: an AES-128 key expansion model answers the
// start_expansion pulse, reads go through a scoreboard queue checked by a
// separate monitor, and status/timing is checked cycle by cycle per load.
module tb_round_key_store;
    import round_key_store_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    round_key_store_if bus ();

    round_key_store dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic rd_req = 1'b0;
    key_t exp_q [$];
    key_t model [11];
    key_t ld_key = '0;
    int   exp_fin_k = 10;
    logic [7:0] sb_tab [256];

    localparam key_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam key_t FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam key_t FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // ---------------- AES key schedule reference ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic expand(input key_t k, output key_t rk [11]);
        word_t w [44];
        word_t t;
        logic [7:0] rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[3-i];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]}
                    ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_read(input int idx);
        @(negedge clk);
        bus.rd_round = 4'(idx);
        rd_req = 1'b1;
        exp_q.push_back(idx <= 10 ? model[idx] : key_t'('0));
    endtask

    task automatic sb_read_const(input int idx, input key_t value);
        @(negedge clk);
        bus.rd_round = 4'(idx);
        rd_req = 1'b1;
        exp_q.push_back(value);
    endtask

    task automatic sb_idle();
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 11; i++) sb_read(i);
        sb_idle();
    endtask

    // Monitor: rd_key is valid the cycle after a tracked read request.
    initial begin
        logic vld;
        key_t e;
        forever begin
            @(posedge clk);
            vld = rd_req;
            @(negedge clk);
            if (vld) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_key: got %h with no expected entry", bus.rd_key);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rd_key !== e) begin
                        n_bad++;
                        $display("FAIL rd_key: got %h expected %h", bus.rd_key, e);
                    end
                end
            end
        end
    end

    // Key expansion model: streams round keys 1..10 after start_expansion.
    initial begin
        key_t erk [11];
        bus.next_key = '0;
        bus.finished_expansion = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.start_expansion === 1'b1) begin
                expand(ld_key, erk);
                for (int k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    bus.next_key = erk[k];
                    bus.finished_expansion = (k == exp_fin_k);
                end
                @(negedge clk);
                bus.next_key = '0;
                bus.finished_expansion = 1'b0;
            end
        end
    end

    // One accepted load, cycle T = load_key high; checks run in cycle T+c.
    task automatic run_load(input key_t key, input int fin_k, input bit ign,
                            input bit rd5, input int rst_at);
        key_t newm [11];
        key_t old5;
        old5 = model[5];
        expand(key, newm);
        ld_key = key;
        exp_fin_k = fin_k;
        @(negedge clk);
        bus.load_key = 1'b1;
        bus.cipher_key = key;
        @(negedge clk);
        bus.load_key = 1'b0;
        bus.cipher_key = {$urandom, $urandom, $urandom, $urandom};
        check("start_t1", bus.start_expansion, 1);
        check("busy_t1", bus.busy, 1);
        check("ready_t1", bus.keys_ready, 0);
        check("err_clr_t1", bus.sched_err, 0);
        check("prev_key_t1", bus.prev_key, key);
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            bus.load_key = ign && (c == 3 || c == 7);
            if (c == rst_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_ready", bus.keys_ready, 0);
                check("rst_prev", bus.prev_key, 0);
                check("rst_rdkey", bus.rd_key, 0);
                @(negedge clk);
                reset_n = 1'b1;
                for (int i = 0; i < 11; i++) model[i] = '0;
                repeat (8) @(negedge clk);
                return;
            end
            if (c == 2) check("start_t2", bus.start_expansion, 0);
            if (rd5 && c == 6) check("rd5_old", bus.rd_key, old5);
            if (rd5 && c == 8) check("rd5_new", bus.rd_key, newm[5]);
            if (c == 11) begin
                check("ready_t11", bus.keys_ready, 0);
                check("busy_t11", bus.busy, 1);
            end
        end
        bus.load_key = 1'b0;
        check("ready_t12", bus.keys_ready, 1);
        check("busy_t12", bus.busy, 0);
        check("err_t12", bus.sched_err, (fin_k != 10));
        check("prev_key_t12", bus.prev_key, key);
        for (int i = 0; i < 11; i++) model[i] = newm[i];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        key_t k;
        int idx;
        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));
        for (int i = 0; i < 11; i++) model[i] = '0;
        bus.load_key = 1'b0;
        bus.cipher_key = '0;
        bus.rd_round = '0;
        repeat (3) @(negedge clk);
        check("reset_rdkey", bus.rd_key, 0);
        check("reset_start", bus.start_expansion, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_err", bus.sched_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.keys_ready, 0);
        check("idle_prev", bus.prev_key, 0);
        for (int i = 0; i < 16; i++) sb_read(i);
        sb_idle();

        // FIPS-197 reference key
        run_load(FIPS_KEY, 10, 0, 0, 0);
        sb_read_const(1, FIPS_RK1);
        sb_read_const(10, FIPS_RK10);
        sb_read_const(0, FIPS_KEY);
        read_all();

        // extra load_key pulses during START/CAPTURE are ignored
        run_load(FIPS_KEY, 10, 1, 0, 0);
        sb_read_const(1, FIPS_RK1);
        read_all();

        // early and withheld finished_expansion, then clean reload
        run_load({$urandom, $urandom, $urandom, $urandom}, 8, 0, 0, 0);
        read_all();
        run_load({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0);
        read_all();
        run_load({$urandom, $urandom, $urandom, $urandom}, 10, 0, 0, 0);

        // rd_round held at 5 across a reload
        @(negedge clk);
        bus.rd_round = 4'd5;
        rd_req = 1'b0;
        @(negedge clk);
        run_load({$urandom, $urandom, $urandom, $urandom}, 10, 0, 1, 0);
        sb_read(11);
        read_all();

        // reset mid-CAPTURE, then a normal load
        run_load({$urandom, $urandom, $urandom, $urandom}, 10, 0, 0, 6);
        read_all();
        run_load({$urandom, $urandom, $urandom, $urandom}, 10, 0, 0, 0);
        read_all();

        // random keys and random reads
        for (int n = 0; n < 3; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_load(k, 10, 0, 0, 0);
            for (int r = 0; r < 20; r++) begin
                idx = $urandom_range(0, 15);
                sb_read(idx);
            end
            sb_idle();
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d reads left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
